open_loop_buf_arb: RTL
======================

Name: open_loop_buf_arb

Overview:
- Shares the single app-side TCP buffer access path between NUM_SRC requesters: setup handler, send loop and recv loop. The path covers the buffer-read and buffer-write request/response channels.
- Grants one requester at a time, round-robin.
- Holds the grant for a whole multi-phase transaction, then releases it:
  - read: request, then response beats;
  - write: request, then data beats, then done.
- Drives the datapath mux select that steers payload fields onto the shared channels. The arbiter itself carries only control.

Parameters:
- NUM_SRC, 3, number of requesters; index 0 = setup handler.
- SRC_W, $clog2(NUM_SRC), grant index width.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- src_req_val  in  NUM_SRC  per-source request valid
- src_req_wr  in  NUM_SRC  per-source request type: 1 = write, 0 = read; sampled at grant
- src_req_rdy  out  NUM_SRC  per-source request accept
- src_wr_data_val  in  NUM_SRC  per-source write-data valid
- src_wr_data_last  in  NUM_SRC  per-source final write-data beat
- src_wr_data_rdy  out  NUM_SRC
- src_wr_done_rdy  in  NUM_SRC
- src_wr_done_val  out  NUM_SRC
- src_rd_resp_rdy  in  NUM_SRC
- src_rd_resp_val  out  NUM_SRC
- buf_rd_req_val  out  1 ; buf_rd_req_rdy  in  1
- buf_rd_resp_val  in  1 ; buf_rd_resp_last  in  1 ; buf_rd_resp_rdy  out  1
- buf_wr_req_val  out  1 ; buf_wr_req_rdy  in  1
- buf_wr_data_val  out  1 ; buf_wr_data_rdy  in  1
- buf_wr_done_val  in  1 ; buf_wr_done_rdy  out  1
- grant_idx  out  SRC_W  datapath mux select; valid while busy
- busy  out  1  a transaction is in flight
- xact_cnt  out  CNT_W  completed transactions, wraps

Behaviour:
- Reset (async assert, sync deassert):
  - state = IDLE, rr_ptr = 0, grant_idx = 0, xact_cnt = 0.
  - All val/rdy outputs are 0 and busy = 0.
- All val/rdy outputs are combinational from state and grant_idx. Every non-granted source sees 0 on all of its rdy/val outputs.
- IDLE:
  - Pick the first set src_req_val bit searching from rr_ptr upward, wrapping modulo NUM_SRC.
  - Register the winner in grant_idx and latch its src_req_wr into wr_reg.
  - Go to REQ next cycle. Arbitration costs exactly 1 cycle.
  - No request pending: stay in IDLE.
- REQ:
  - Forward src_req_val[g] to buf_wr_req_val if wr_reg is 1, otherwise to buf_rd_req_val. Return the matching rdy on src_req_rdy[g].
  - On handshake, go to WDATA (write) or RDRESP (read).
  - If the source drops val before the handshake (protocol violation), stay in REQ; no deadlock recovery.
- WDATA:
  - Pass through buf_wr_data_val/rdy.
  - A handshake with src_wr_data_last[g] = 1 moves to WDONE.
- WDONE:
  - Pass through buf_wr_done_val and src_wr_done_rdy[g].
  - On handshake, move to RELEASE.
- RDRESP:
  - Pass through buf_rd_resp_val and src_rd_resp_rdy[g].
  - A handshake with buf_rd_resp_last = 1 moves to RELEASE.
- RELEASE (1 cycle):
  - rr_ptr = (g+1) mod NUM_SRC; xact_cnt += 1, wrapping.
  - Go to IDLE.
  - Back-to-back requests from a single source therefore pay 2 idle cycles.
- busy = 1 in REQ, WDATA, WDONE, RDRESP and RELEASE.
- Simultaneous requests resolve by rr_ptr. A source that just released has lowest priority.
- Requests arriving mid-transaction wait; no preemption.
- rst_n asserted mid-transaction drops all handshakes immediately. Upstream units are reset by the same rst_n.
- Illegal state: outputs X, next state X, for simulation detection.

Decomposition:
- open_loop_pkg gains:
  - arb_state_e (IDLE, REQ, WDATA, WDONE, RDRESP, RELEASE);
  - localparam OL_BUF_SRC_SETUP = 0, OL_BUF_SRC_SEND = 1, OL_BUF_SRC_RECV = 2.
- One sub-module: rr_pick_next. It is a combinational round-robin picker with inputs (req vector, rr_ptr) and outputs (valid, idx). It is reusable by other app arbiters.

Test Plan:
- Single read: src1 requests read; resp beats with last on beat 3. Required:
  - grant_idx = 1 the cycle after req;
  - buf_rd_req_val follows;
  - src_rd_resp_val[1] shows 3 beats;
  - xact_cnt = 1, busy low 1 cycle after RELEASE.
- Single write: src0 requests write; 4 data beats, then done. Required:
  - buf_wr_data_val mirrors src0 only;
  - src_wr_done_val[0] pulses;
  - rr_ptr = 1 afterwards.
- Contention: all 3 sources assert read at once, each transaction 1 beat. Required:
  - grant order 0, 1, 2;
  - src0 re-requesting immediately is served after 2;
  - xact_cnt = 4.
- Backpressure: buf_wr_data_rdy held low 5 cycles mid-write. Required:
  - state stays WDATA;
  - no other source gets rdy;
  - beats complete in order.
- Async reset: rst_n pulsed low for half a cycle during RDRESP. Required:
  - all outputs 0 immediately;
  - state IDLE;
  - xact_cnt = 0;
  - the next request is granted normally.
- Wrap: force xact_cnt to 16'hFFFF and complete one transaction. Required: xact_cnt = 0.

Source files
------------

// File: rtl/open_loop_pkg.sv
// Shared types for the open-loop app-side buffer path: arbiter FSM states
// and the fixed requester index assignment used by the datapath mux.
package open_loop_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WDATA   = 3'd2,
    WDONE   = 3'd3,
    RDRESP  = 3'd4,
    RELEASE = 3'd5
  } arb_state_e;

  localparam int OL_BUF_SRC_SETUP = 0;
  localparam int OL_BUF_SRC_SEND  = 1;
  localparam int OL_BUF_SRC_RECV  = 2;

endpackage

// File: rtl/open_loop_buf_arb_if.sv
// Per-source and shared buffer-side handshakes of the app buffer path.
// master = arbiter view, slave = requesters plus buffer view.
interface open_loop_buf_arb_if #(
  parameter int NUM_SRC = 3
);
  logic [NUM_SRC-1:0] src_req_val;
  logic [NUM_SRC-1:0] src_req_wr;
  logic [NUM_SRC-1:0] src_req_rdy;
  logic [NUM_SRC-1:0] src_wr_data_val;
  logic [NUM_SRC-1:0] src_wr_data_last;
  logic [NUM_SRC-1:0] src_wr_data_rdy;
  logic [NUM_SRC-1:0] src_wr_done_rdy;
  logic [NUM_SRC-1:0] src_wr_done_val;
  logic [NUM_SRC-1:0] src_rd_resp_rdy;
  logic [NUM_SRC-1:0] src_rd_resp_val;
  logic               buf_rd_req_val;
  logic               buf_rd_req_rdy;
  logic               buf_rd_resp_val;
  logic               buf_rd_resp_last;
  logic               buf_rd_resp_rdy;
  logic               buf_wr_req_val;
  logic               buf_wr_req_rdy;
  logic               buf_wr_data_val;
  logic               buf_wr_data_rdy;
  logic               buf_wr_done_val;
  logic               buf_wr_done_rdy;

  modport master (
    input  src_req_val, src_req_wr, src_wr_data_val, src_wr_data_last,
           src_wr_done_rdy, src_rd_resp_rdy,
           buf_rd_req_rdy, buf_rd_resp_val, buf_rd_resp_last,
           buf_wr_req_rdy, buf_wr_data_rdy, buf_wr_done_val,
    output src_req_rdy, src_wr_data_rdy, src_wr_done_val, src_rd_resp_val,
           buf_rd_req_val, buf_rd_resp_rdy, buf_wr_req_val,
           buf_wr_data_val, buf_wr_done_rdy
  );

  modport slave (
    output src_req_val, src_req_wr, src_wr_data_val, src_wr_data_last,
           src_wr_done_rdy, src_rd_resp_rdy,
           buf_rd_req_rdy, buf_rd_resp_val, buf_rd_resp_last,
           buf_wr_req_rdy, buf_wr_data_rdy, buf_wr_done_val,
    input  src_req_rdy, src_wr_data_rdy, src_wr_done_val, src_rd_resp_val,
           buf_rd_req_val, buf_rd_resp_rdy, buf_wr_req_val,
           buf_wr_data_val, buf_wr_done_rdy
  );
endinterface

// File: rtl/open_loop_buf_arb_rr_pick_next.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr,
// wrapping modulo N. No state, zero latency.
module rr_pick_next #(
  parameter int N = 3,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  // Scan from the farthest offset down so the nearest candidate wins last.
  always_comb begin
    logic [W:0] cand;
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (W+1)'(i);
      if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
      if (req[cand[W-1:0]]) begin
        valid = 1'b1;
        idx   = cand[W-1:0];
      end
    end
  end

endmodule

// File: rtl/open_loop_buf_arb.sv
// Round-robin owner of the app-side buffer path; 1-cycle arbitration, grant held
// for a whole read/write transaction plus a 1-cycle release. Control only, handshakes pass through.
module open_loop_buf_arb
  import open_loop_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int SRC_W   = $clog2(NUM_SRC),
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  open_loop_buf_arb_if.master bus,
  output logic [SRC_W-1:0]    grant_idx,
  output logic                busy,
  output logic [CNT_W-1:0]    xact_cnt
);

  arb_state_e       state, state_d;
  logic [SRC_W-1:0] rr_ptr;
  logic             wr_reg;
  logic             pick_valid;
  logic [SRC_W-1:0] pick_idx;
  logic [SRC_W-1:0] ptr_after;

  rr_pick_next #(.N(NUM_SRC), .W(SRC_W)) u_pick (
    .req    (bus.src_req_val),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  assign ptr_after = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      wr_reg    <= 1'b0;
      xact_cnt  <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && pick_valid) begin
        grant_idx <= pick_idx;
        wr_reg    <= bus.src_req_wr[pick_idx];
      end
      if (state == RELEASE) begin
        rr_ptr   <= ptr_after;
        xact_cnt <= xact_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_d             = state;
    bus.src_req_rdy     = '0;
    bus.src_wr_data_rdy = '0;
    bus.src_wr_done_val = '0;
    bus.src_rd_resp_val = '0;
    bus.buf_rd_req_val  = 1'b0;
    bus.buf_rd_resp_rdy = 1'b0;
    bus.buf_wr_req_val  = 1'b0;
    bus.buf_wr_data_val = 1'b0;
    bus.buf_wr_done_rdy = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) state_d = REQ;
      end
      REQ: begin
        if (wr_reg) begin
          bus.buf_wr_req_val         = bus.src_req_val[grant_idx];
          bus.src_req_rdy[grant_idx] = bus.buf_wr_req_rdy;
          if (bus.src_req_val[grant_idx] && bus.buf_wr_req_rdy) state_d = WDATA;
        end else begin
          bus.buf_rd_req_val         = bus.src_req_val[grant_idx];
          bus.src_req_rdy[grant_idx] = bus.buf_rd_req_rdy;
          if (bus.src_req_val[grant_idx] && bus.buf_rd_req_rdy) state_d = RDRESP;
        end
      end
      WDATA: begin
        bus.buf_wr_data_val            = bus.src_wr_data_val[grant_idx];
        bus.src_wr_data_rdy[grant_idx] = bus.buf_wr_data_rdy;
        if (bus.src_wr_data_val[grant_idx] && bus.buf_wr_data_rdy &&
            bus.src_wr_data_last[grant_idx]) state_d = WDONE;
      end
      WDONE: begin
        bus.src_wr_done_val[grant_idx] = bus.buf_wr_done_val;
        bus.buf_wr_done_rdy            = bus.src_wr_done_rdy[grant_idx];
        if (bus.buf_wr_done_val && bus.src_wr_done_rdy[grant_idx]) state_d = RELEASE;
      end
      RDRESP: begin
        bus.src_rd_resp_val[grant_idx] = bus.buf_rd_resp_val;
        bus.buf_rd_resp_rdy            = bus.src_rd_resp_rdy[grant_idx];
        if (bus.buf_rd_resp_val && bus.src_rd_resp_rdy[grant_idx] &&
            bus.buf_rd_resp_last) state_d = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        // Unreachable encodings propagate X so simulation flags them.
        state_d             = arb_state_e'('x);
        bus.src_req_rdy     = 'x;
        bus.src_wr_data_rdy = 'x;
        bus.src_wr_done_val = 'x;
        bus.src_rd_resp_val = 'x;
        bus.buf_rd_req_val  = 1'bx;
        bus.buf_rd_resp_rdy = 1'bx;
        bus.buf_wr_req_val  = 1'bx;
        bus.buf_wr_data_val = 1'bx;
        bus.buf_wr_done_rdy = 1'bx;
      end
    endcase
  end

endmodule
